// File: rtl/fp_norm_round_pkg.sv
// Shared constants and types for the floating-point normalise/round pipeline.
// Raw mantissa layout (LSB first): sticky, round, guard, fraction, hidden, carry.
package fp_norm_round_pkg;

  localparam int FP_WIDTH     = 32;
  localparam int FP_EXP_BITS  = 8;
  localparam int FP_MANT_BITS = 23;
  localparam int FP_BIAS      = (1 << (FP_EXP_BITS - 1)) - 1;

  // Field positions inside the raw mantissa; carry/hidden are offsets above MANT_BITS.
  localparam int RAW_CARRY_OFS  = 4;
  localparam int RAW_HIDDEN_OFS = 3;
  localparam int RAW_FRAC_LSB   = 3;
  localparam int RAW_GUARD      = 2;
  localparam int RAW_ROUND      = 1;
  localparam int RAW_STICKY     = 0;

  typedef struct packed {
    logic                    sign;
    logic [FP_EXP_BITS-1:0]  exp;
    logic [FP_MANT_BITS-1:0] frac;
  } fp_word_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter: number of zeros above the most significant set bit.
// An all-zero input returns WIDTH.
module fp_lzc #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count
);

  // Scanning upward lets the highest set bit be the last (winning) assignment.
  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage normalise (S1) and round-to-nearest-even/pack (S2) pipeline for
// raw adder results. Handshake: a beat moves when valid and ready are both high.
module fp_norm_round
  import fp_norm_round_pkg::*;
#(
  parameter int WIDTH     = FP_WIDTH,
  parameter int EXP_BITS  = FP_EXP_BITS,
  parameter int MANT_BITS = FP_MANT_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_BITS-1:0]  in_exp,
  input  logic [MANT_BITS+4:0] in_mant,
  input  logic                 in_special,
  input  logic [WIDTH-1:0]     in_special_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic [2:0]           flags
);

  localparam int EXPW  = EXP_BITS + 2;
  localparam int NRMW  = MANT_BITS + 4;
  localparam int LZW   = MANT_BITS + 2;
  localparam int LZCW  = $clog2(LZW + 1);
  localparam int C_IDX = MANT_BITS + RAW_CARRY_OFS;
  localparam int H_IDX = MANT_BITS + RAW_HIDDEN_OFS;

  localparam logic signed [EXPW-1:0] E_ZERO = '0;
  localparam logic signed [EXPW-1:0] E_ONE  = EXPW'(1);
  localparam logic signed [EXPW-1:0] E_MAX  = EXPW'((1 << EXP_BITS) - 1);

  // Pipeline control
  logic w_s1_load;
  logic w_s2_load;

  // Stage 1 registers
  logic                   r_s1_valid;
  logic                   r_s1_special;
  logic [WIDTH-1:0]       r_s1_sval;
  logic                   r_s1_sign;
  logic                   r_s1_zero;
  logic signed [EXPW-1:0] r_s1_exp;
  logic [NRMW-1:0]        r_s1_mant;

  // Stage 2 registers
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_flags;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = rst_n && w_s1_load;
  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign flags     = r_flags;

  // ---------------- S1: normalise ----------------
  logic [LZCW-1:0]        w_lz;
  logic signed [EXPW-1:0] w_exp_in;
  logic signed [EXPW-1:0] w_limit;
  logic signed [EXPW-1:0] w_lz_ext;
  logic signed [EXPW-1:0] w_shift;
  logic signed [EXPW-1:0] w_s1_exp;
  logic [NRMW-1:0]        w_s1_mant;
  logic                   w_mant_zero;

  fp_lzc #(.WIDTH(LZW)) u_lzc (
    .i_data  (in_mant[H_IDX:RAW_GUARD]),
    .o_count (w_lz)
  );

  always_comb begin
    w_exp_in    = {2'b00, in_exp};
    w_limit     = (w_exp_in > E_ZERO) ? w_exp_in - E_ONE : E_ZERO;
    w_lz_ext    = EXPW'(w_lz);
    w_shift     = (w_lz_ext > w_limit) ? w_limit : w_lz_ext;
    w_mant_zero = (in_mant == '0);
    if (in_mant[C_IDX]) begin
      w_s1_mant = {in_mant[C_IDX:RAW_GUARD], in_mant[RAW_ROUND] | in_mant[RAW_STICKY]};
      w_s1_exp  = w_exp_in + E_ONE;
    end else begin
      w_s1_mant = in_mant[NRMW-1:0] << w_shift;
      w_s1_exp  = w_exp_in - w_shift;
    end
    // A shift limited by the exponent leaves the hidden bit clear: subnormal.
    if (!w_s1_mant[NRMW-1]) w_s1_exp = E_ZERO;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_special <= 1'b0;
      r_s1_sval    <= '0;
      r_s1_sign    <= 1'b0;
      r_s1_zero    <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_mant    <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_special <= in_special;
        r_s1_sval    <= in_special_val;
        r_s1_sign    <= in_sign;
        r_s1_zero    <= w_mant_zero;
        r_s1_exp     <= w_s1_exp;
        r_s1_mant    <= w_s1_mant;
      end
    end
  end

  // ---------------- S2: round and pack ----------------
  logic                   w_hidden;
  logic                   w_lsb;
  logic                   w_g;
  logic                   w_r;
  logic                   w_s;
  logic                   w_inexact;
  logic                   w_inc;
  logic [MANT_BITS+1:0]   w_sig;
  logic signed [EXPW-1:0] w_exp_fin;
  logic [MANT_BITS-1:0]   w_frac;
  logic                   w_ovf;
  logic [WIDTH-1:0]       w_result;
  logic [2:0]             w_flags;

  always_comb begin
    w_hidden  = r_s1_mant[NRMW-1];
    w_lsb     = r_s1_mant[RAW_FRAC_LSB];
    w_g       = r_s1_mant[RAW_GUARD];
    w_r       = r_s1_mant[RAW_ROUND];
    w_s       = r_s1_mant[RAW_STICKY];
    w_inexact = w_g | w_r | w_s;
    w_inc     = w_g & (w_r | w_s | w_lsb);
    w_sig     = {1'b0, r_s1_mant[NRMW-1:RAW_FRAC_LSB]} + {{(MANT_BITS+1){1'b0}}, w_inc};
    // Carry out of the hidden bit bumps the exponent; a subnormal that rounds
    // up into the hidden position becomes the smallest normal.
    w_exp_fin = r_s1_exp
              + {{(EXPW-1){1'b0}}, w_sig[MANT_BITS+1]}
              + {{(EXPW-1){1'b0}}, !w_hidden & w_sig[MANT_BITS]};
    w_frac    = w_sig[MANT_BITS+1] ? '0 : w_sig[MANT_BITS-1:0];
    w_ovf     = (w_exp_fin >= E_MAX);

    w_result = '0;
    w_flags  = 3'b000;
    if (r_s1_special) begin
      w_result = r_s1_sval;
    end else if (r_s1_zero) begin
      w_result = '0;
    end else if (w_ovf) begin
      w_result = {r_s1_sign, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
      w_flags  = 3'b101;
    end else begin
      w_result = {r_s1_sign, w_exp_fin[EXP_BITS-1:0], w_frac};
      w_flags  = {1'b0, (w_exp_fin == E_ZERO) & w_inexact, w_inexact};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_flags    <= 3'b000;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_result;
        r_flags  <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: hand-computed single-precision vectors,
// backpressure ordering and mid-flight reset.
module tb_fp_norm_round;
  import fp_norm_round_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic        in_special = 1'b0;
  logic [31:0] in_special_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [2:0]  flags;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  localparam logic [27:0] CARRY    = 28'h8000000;
  localparam logic [27:0] HIDDEN   = 28'h4000000;
  localparam logic [27:0] FMSB     = 28'h2000000;
  localparam logic [27:0] FRAC_ALL = 28'h3FFFFF8;
  localparam logic [27:0] GRD      = 28'h0000004;
  localparam logic [27:0] RND      = 28'h0000002;
  localparam logic [27:0] STK      = 28'h0000001;

  fp_norm_round dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign        (in_sign),
    .in_exp         (in_exp),
    .in_mant        (in_mant),
    .in_special     (in_special),
    .in_special_val (in_special_val),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .flags          (flags)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] fpw(input logic s, input logic [7:0] e, input logic [22:0] f);
    fp_word_t w;
    w.sign = s;
    w.exp  = e;
    w.frac = f;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic sp, input logic [31:0] spv, input logic sg,
                       input logic [7:0] e, input logic [27:0] m);
    in_valid       = 1'b1;
    in_special     = sp;
    in_special_val = spv;
    in_sign        = sg;
    in_exp         = e;
    in_mant        = m;
  endtask

  task automatic run_one(input string tag, input logic sp, input logic [31:0] spv,
                         input logic sg, input logic [7:0] e, input logic [27:0] m,
                         input logic [31:0] er, input logic [2:0] ef);
    int n;
    drive(sp, spv, sg, e, m);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, result, er);
    chk({tag, "_flags"}, 32'(flags), {29'd0, ef});
    step();
  endtask

  // ---------------- stimulus and scoreboard ----------------
  initial begin
    int got;
    int n;
    logic acc;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Latency: carry-only mantissa gives 2.0 two edges after acceptance
    step();
    drive(1'b0, 32'd0, 1'b0, 8'd127, CARRY);
    @(negedge clk);
    chk("lat_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_s1_not_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_result", result, 32'h40000000);
    chk("lat_flags", 32'(flags), 32'd0);
    step();
    @(negedge clk);
    chk("lat_drained", 32'(out_valid), 32'd0);
    step();

    // Directed vectors
    run_one("neg_norm",     0, 0, 1, 8'd130, HIDDEN,                 fpw(1, 8'd130, 23'd0), 3'b000);
    run_one("half",         0, 0, 0, 8'd127, FMSB,                   32'h3F000000, 3'b000);
    run_one("tie_odd_up",   0, 0, 0, 8'd127, HIDDEN | 28'h8 | GRD,   32'h3F800002, 3'b001);
    run_one("tie_even",     0, 0, 0, 8'd127, HIDDEN | GRD,           32'h3F800000, 3'b001);
    run_one("carry_ovf",    0, 0, 0, 8'd254, CARRY,                  32'h7F800000, 3'b101);
    run_one("rnd_carry",    0, 0, 0, 8'd127, HIDDEN | FRAC_ALL | GRD, 32'h40000000, 3'b001);
    run_one("rnd_ovf",      0, 0, 1, 8'd254, HIDDEN | FRAC_ALL | GRD, 32'hFF800000, 3'b101);
    run_one("carry_tie",    0, 0, 0, 8'd127, CARRY | 28'h18,         32'h40000002, 3'b001);
    run_one("carry_sticky", 0, 0, 0, 8'd127, CARRY | STK,            32'h40000000, 3'b001);
    run_one("deep_shift",   0, 0, 0, 8'd127, 28'h8,                  32'h34000000, 3'b000);
    run_one("zero_mant",    0, 0, 1, 8'd100, 28'd0,                  32'h00000000, 3'b000);
    run_one("special",      1, 32'hFFC00001, 0, 8'd254, CARRY,       32'hFFC00001, 3'b000);
    run_one("sub_exact",    0, 0, 0, 8'd1,   28'h1000000,            32'h00200000, 3'b000);
    run_one("sub_inexact",  0, 0, 0, 8'd1,   28'h1000000 | RND,      32'h00200000, 3'b011);
    run_one("sub_limit",    0, 0, 0, 8'd3,   28'h0800000,            32'h00400000, 3'b000);
    run_one("sub_to_norm",  0, 0, 0, 8'd1,   FRAC_ALL | GRD,         32'h00800000, 3'b001);

    // Backpressure: two accepts fill the pipe, third waits, order preserved
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 8'd127, HIDDEN);
    exp_q.push_back(32'h3F800000);
    @(negedge clk);
    chk("bp_ready1", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 32'd0, 1'b0, 8'd128, HIDDEN);
    exp_q.push_back(32'h40000000);
    @(negedge clk);
    chk("bp_ready2", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 32'd0, 1'b0, 8'd129, HIDDEN);
    exp_q.push_back(32'h40800000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_stall_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", result, 32'h3F800000);
      step();
    end
    out_ready = 1'b1;
    got = 0;
    n = 0;
    while (got < 3 && n < 20) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk("bp_order", result, exp_q.pop_front());
        got++;
      end
      step();
      if (acc) in_valid = 1'b0;
      n++;
    end
    chk("bp_count", 32'(got), 32'd3);

    // Reset with two items in flight
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 8'd130, HIDDEN);
    @(negedge clk);
    step();
    drive(1'b0, 32'd0, 1'b1, 8'd131, HIDDEN);
    @(negedge clk);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("inflight_valid", 32'(out_valid), 32'd1);
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("no_stale", 32'(out_valid), 32'd0);
    end
    step();
    run_one("post_rst", 0, 0, 0, 8'd127, FMSB | 28'h1000000, 32'h3F400000, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_norm_round.md
FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 SHALL have parameter WIDTH, default 32, total IEEE-754 word width.
REQ-002 SHALL have parameter EXP_BITS, default 8, exponent field width.
REQ-003 SHALL have parameter MANT_BITS, default 23, stored fraction width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream adder/subtractor raw result valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a raw result this cycle.
REQ-008 SHALL have port in_sign  input  1  raw result sign.
REQ-009 SHALL have port in_exp  input  EXP_BITS  biased exponent of the larger operand.
REQ-010 SHALL have port in_mant  input  MANT_BITS+5  bits [MANT_BITS+4]=carry, [MANT_BITS+3]=hidden, [MANT_BITS+2:3]=fraction, [2]=guard, [1]=round, [0]=sticky.
REQ-011 SHALL have port in_special  input  1  upstream-resolved NaN/Inf/zero case; bypasses normalisation.
REQ-012 SHALL have port in_special_val  input  WIDTH  result word used when in_special=1.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-015 SHALL have port result  output  WIDTH  packed sign|exponent|fraction.
REQ-016 SHALL have port flags  output  3  {overflow, underflow, inexact}.

Function
REQ-017 SHALL be a 2-stage pipeline (S1 normalise, S2 round/pack) with latency 2 cycles from accepted input to out_valid when out_ready stays high.
REQ-018 SHALL transfer on in_valid&in_ready (input) and out_valid&out_ready (output); result/flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 S2 register SHALL load when empty or being consumed; S1 SHALL load when empty or advancing into S2; in_ready = !S1_valid || S1 advancing (sustains 1 item/cycle).
REQ-020 S1, carry=1: shift mantissa right by 1, exp+1, shifted-out bit ORed into sticky.
REQ-021 S1, carry=0: left shift by min(lzc(hidden..guard), in_exp-1), exp reduced by that amount; if limited, the result is subnormal with stored exponent 0.
REQ-022 S1, mantissa all zero: result SHALL be +0 (sign 0), flags 000.
REQ-023 S2 SHALL round to nearest, ties to even: increment when G&(R|S|LSB); inexact = G|R|S.
REQ-024 Rounding carry out of the hidden bit SHALL increment exponent and renormalise.
REQ-025 Final exponent >= 2^EXP_BITS-1 SHALL give ±Inf (fraction 0), overflow=1, inexact=1.
REQ-026 underflow SHALL be 1 when result is subnormal or zero from a nonzero mantissa and inexact=1.
REQ-027 in_special=1 SHALL pass in_special_val unchanged through both stages with flags 000, preserving order.
REQ-028 Exponent arithmetic SHALL use EXP_BITS+2 signed internal width; no wrap-around.

Reset
REQ-029 rst_n=0 at a clock edge SHALL clear S1/S2 valid, out_valid=0, result=0, flags=000, in_ready=0 while rst_n=0.
REQ-030 Reset mid-operation SHALL discard in-flight items; first cycle after release in_ready=1.

Structure
REQ-031 A shared package SHALL hold WIDTH/EXP_BITS/MANT_BITS defaults, the raw-mantissa field index constants, the bias constant and a packed result struct (sign, exp, frac).
REQ-032 The leading-zero counter SHALL be a separate sub-module fp_lzc, parameterised by width.

Verification
REQ-033 in_exp=127, in_mant=carry bit only -> result 0x40000000, flags 000, 2 cycles later.
REQ-034 in_exp=127, in_mant=fraction MSB only (hidden 0) -> result 0x3F000000 (0.5), flags 000.
REQ-035 in_exp=127, hidden=1, fraction=1, G=1, R=S=0 -> result 0x3F800002, flags 001; same with fraction=0 -> 0x3F800000, flags 001.
REQ-036 in_exp=254, carry=1 -> result 0x7F800000, flags 101.
REQ-037 Three back-to-back inputs, out_ready=0 for 4 cycles -> in_ready drops after 2 accepts, result held, all three delivered in order once out_ready=1.
REQ-038 Assert rst_n=0 with 2 items in flight -> out_valid=0 next cycle, no stale result after release.
